// File: rtl/ssd_pkg.sv
// Shared constants for the seven-segment scan path: active-low segment table and off values.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
//
// Segment bit order is {a,b,c,d,e,f,g}; a 0 lights the segment.
package ssd_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic       DP_OFF  = 1'b1;

  // Entry n is the pattern for hex digit n (entry 0 sits in the low bits).
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_TABLE[nib];
  endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern lookup.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
//
// Ports:
//   nibble    in   4  hex value to display
//   segments  out  7  active-low {a,b,c,d,e,f,g}
module ssd_hex_decode
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = hex_to_seg(nibble);

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Double-buffered multiplexed seven-segment scan controller with frame-synchronous buffer swap.
// Latency: pins are registered, 1 cycle after the digit index advances or a swap; loads show after the next wrap.
// Backpressure: none; load always accepted, last load before a wrap wins.
//
// Ports:
//   clk         in   1             system clock
//   reset       in   1             asynchronous active-low reset
//   load        in   1             strobe, captures digits_in/dp_in/blank_in into the pending buffer
//   digits_in   in   4*NUM_DIGITS  hex nibble per digit, digit 0 in [3:0]
//   dp_in       in   NUM_DIGITS    decimal point per digit, 1 = lit
//   blank_in    in   NUM_DIGITS    1 = digit dark
//   anodes      out  NUM_DIGITS    active-low one-hot digit enables
//   cathodes    out  7             active-low segments {a,b,c,d,e,f,g}
//   dp          out  1             active-low decimal point
//   frame_done  out  1             one-cycle pulse on scan wrap
//   pending     out  1             loaded frame awaiting swap
//
// Build option: SSD_LZ_SUPPRESS_EN enables leading-zero suppression at display time.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DIV_BITS   = 17
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [6:0]              cathodes,
  output logic                    dp,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int                    IDX_W     = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_ONE = NUM_DIGITS'(1);

  logic [DIV_BITS-1:0]     pre;
  logic [IDX_W-1:0]        idx;
  logic [4*NUM_DIGITS-1:0] act_nib, pnd_nib;
  logic [NUM_DIGITS-1:0]   act_dp, pnd_dp;
  logic [NUM_DIGITS-1:0]   act_blank, pnd_blank;
  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [NUM_DIGITS-1:0]   dark;
  logic [3:0]              sel_nib;
  logic [6:0]              sel_seg;
  logic                    tick;
  logic                    wrap;

  assign tick = &pre;
  assign wrap = tick && (idx == LAST_IDX);

`ifdef SSD_LZ_SUPPRESS_EN
  // Walk down from the top digit; a zero without dp is suppressed only while
  // everything above it is already dark. Digit 0 is never suppressed.
  always_comb begin
    logic higher_dark;
    higher_dark = 1'b1;
    lz_mask     = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_mask[i]  = higher_dark && (act_nib[4*i +: 4] == 4'h0) && !act_dp[i];
      higher_dark = higher_dark && (act_blank[i] || lz_mask[i]);
    end
  end
`else
  assign lz_mask = '0;
`endif

  assign dark    = act_blank | lz_mask;
  assign sel_nib = act_nib[{idx, 2'b00} +: 4];

  ssd_hex_decode u_hex_decode (
    .nibble   (sel_nib),
    .segments (sel_seg)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre        <= '0;
      idx        <= '0;
      pending    <= 1'b0;
      frame_done <= 1'b0;
      act_nib    <= '0;
      act_dp     <= '0;
      act_blank  <= '1;
      pnd_nib    <= '0;
      pnd_dp     <= '0;
      pnd_blank  <= '1;
      anodes     <= '1;
      cathodes   <= SEG_OFF;
      dp         <= DP_OFF;
    end else begin
      pre        <= pre + 1'b1;
      frame_done <= wrap;

      if (tick) begin
        idx <= wrap ? '0 : idx + 1'b1;
      end

      // Swap reads the pending buffer before a coincident load overwrites it.
      if (wrap && pending) begin
        act_nib   <= pnd_nib;
        act_dp    <= pnd_dp;
        act_blank <= pnd_blank;
      end

      if (load) begin
        pnd_nib   <= digits_in;
        pnd_dp    <= dp_in;
        pnd_blank <= blank_in;
        pending   <= 1'b1;
      end else if (wrap) begin
        pending   <= 1'b0;
      end

      anodes <= ~(ANODE_ONE << idx);
      if (dark[idx]) begin
        cathodes <= SEG_OFF;
        dp       <= DP_OFF;
      end else begin
        cathodes <= sel_seg;
        dp       <= ~act_dp[idx];
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl: 8-digit and 5-digit instances, tick every 4 clocks.
// Expected values are hand-derived from a bench-side cycle count after reset release.
module tb_ssd_scan_ctrl;

  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };
  localparam logic [6:0] OFF = 7'b1111111;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;

  logic        load      = 1'b0;
  logic [31:0] digits_in = '0;
  logic [7:0]  dp_in     = '0;
  logic [7:0]  blank_in  = '0;
  logic [7:0]  anodes;
  logic [6:0]  cathodes;
  logic        dp, frame_done, pending;

  logic        load5      = 1'b0;
  logic [19:0] digits5_in = '0;
  logic [4:0]  dp5_in     = '0;
  logic [4:0]  blank5_in  = '0;
  logic [4:0]  anodes5;
  logic [6:0]  cathodes5;
  logic        dp5, frame_done5, pending5;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  ssd_scan_ctrl #(.NUM_DIGITS(8), .DIV_BITS(2)) dut (
    .clk(clk), .reset(reset), .load(load), .digits_in(digits_in),
    .dp_in(dp_in), .blank_in(blank_in), .anodes(anodes), .cathodes(cathodes),
    .dp(dp), .frame_done(frame_done), .pending(pending)
  );

  ssd_scan_ctrl #(.NUM_DIGITS(5), .DIV_BITS(2)) dut5 (
    .clk(clk), .reset(reset), .load(load5), .digits_in(digits5_in),
    .dp_in(dp5_in), .blank_in(blank5_in), .anodes(anodes5), .cathodes(cathodes5),
    .dp(dp5), .frame_done(frame_done5), .pending(pending5)
  );

  always #5 clk = ~clk;

  // Clock count since reset release; after posedge number c, cyc == c.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, observed cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_an;
    logic [4:0] exp_an5;
    int         d;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_anodes",   anodes,     8'hFF);
    chk("rst_cathodes", cathodes,   OFF);
    chk("rst_dp",       dp,         1'b1);
    chk("rst_frame",    frame_done, 1'b0);
    chk("rst_pending",  pending,    1'b0);
    chk("rst_anodes5",  anodes5,    5'h1F);
    reset = 1'b1;

    // Blank scan for two frames
    for (int c = 1; c <= 64; c++) begin
      goto(c);
      d      = ((c - 1) / 4) % 8;
      exp_an = ~(8'd1 << d);
      chk("scan_anodes",   anodes,     exp_an);
      chk("scan_cathodes", cathodes,   OFF);
      chk("scan_dp",       dp,         1'b1);
      chk("scan_frame",    frame_done, (c % 32 == 0));
    end

    // Mid-frame load on both instances
    goto(66);
    load = 1'b1; digits_in = 32'h7654_3210; dp_in = '0; blank_in = '0;
    load5 = 1'b1; digits5_in = 20'h43210; dp5_in = 5'b00100; blank5_in = '0;
    goto(67);
    load = 1'b0; load5 = 1'b0;
    goto(70);  chk("ld_pending_mid",  pending, 1'b1);
    goto(95);  chk("ld_pending_pre",  pending, 1'b1);
    goto(96);  chk("ld_pending_post", pending, 1'b0);
               chk("ld_frame",        frame_done, 1'b1);
    goto(97);  chk("ld_d0_anodes",    anodes,   8'hFE);
               chk("ld_d0_cathodes",  cathodes, SEG[0]);

    // Two loads before the next wrap; last one wins
    goto(100); load = 1'b1; digits_in = 32'h1111_1111;
    goto(101); load = 1'b0;
    goto(104); load = 1'b1; digits_in = 32'hFFFF_FFFF;
    goto(105); load = 1'b0;
    goto(117); chk("ld_d5_anodes",    anodes,   8'hDF);
               chk("ld_d5_cathodes",  cathodes, SEG[5]);
               chk("ld_d5_dp",        dp,       1'b1);
    goto(127); chk("dbl_pending_pre", pending,  1'b1);
    goto(128); chk("dbl_pending_post", pending, 1'b0);
    for (int k = 0; k < 8; k++) begin
      goto(129 + 4 * k);
      exp_an = ~(8'd1 << k);
      chk("dbl_anodes",   anodes,   exp_an);
      chk("dbl_cathodes", cathodes, SEG[15]);
    end

    // Load coinciding with the wrap tick
    goto(158); load = 1'b1; digits_in = 32'h2222_2222;
    goto(159); digits_in = 32'h3333_3333;
    goto(160); load = 1'b0;
               chk("coin_pending",   pending,    1'b1);
               chk("coin_frame",     frame_done, 1'b1);
    goto(161); chk("coin_old_shown", cathodes,   SEG[2]);
    goto(191); chk("coin_pending2",  pending,    1'b1);
               chk("coin_old_last",  cathodes,   SEG[2]);
    goto(192); chk("coin_pending3",  pending,    1'b0);
    goto(193); chk("coin_new_shown", cathodes,   SEG[3]);

    // Leading-zero pattern load, then 5-digit scan and decimal point
    goto(200); load = 1'b1; digits_in = 32'h0000_0A05;
    goto(201); load = 1'b0;
    for (int c = 201; c <= 221; c++) begin
      goto(c);
      d       = ((c - 1) / 4) % 5;
      exp_an5 = ~(5'd1 << d);
      chk("n5_anodes",   anodes5,   exp_an5);
      chk("n5_cathodes", cathodes5, SEG[d]);
      chk("n5_dp",       dp5,       (d == 2) ? 1'b0 : 1'b1);
    end

    for (int k = 0; k < 8; k++) begin
      goto(225 + 4 * k);
      exp_an = ~(8'd1 << k);
      chk("lz_anodes", anodes, exp_an);
      chk("lz_dp",     dp,     1'b1);
      case (k)
        0:       chk("lz_cathodes", cathodes, SEG[5]);
        1:       chk("lz_cathodes", cathodes, SEG[0]);
        2:       chk("lz_cathodes", cathodes, SEG[10]);
`ifdef SSD_LZ_SUPPRESS_EN
        default: chk("lz_cathodes", cathodes, OFF);
`else
        default: chk("lz_cathodes", cathodes, SEG[0]);
`endif
      endcase
    end

    // Reset mid-frame with unswapped data pending
    goto(256); load = 1'b1; digits_in = 32'h1234_5678;
    goto(257); load = 1'b0;
    goto(258); chk("mr_pending_pre", pending, 1'b1);
    reset = 1'b0;
    #1;
    chk("mr_anodes",   anodes,     8'hFF);
    chk("mr_cathodes", cathodes,   OFF);
    chk("mr_dp",       dp,         1'b1);
    chk("mr_pending",  pending,    1'b0);
    chk("mr_frame",    frame_done, 1'b0);
    chk("mr_anodes5",  anodes5,    5'h1F);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    goto(1);   chk("rr_anodes",    anodes,     8'hFE);
               chk("rr_cathodes",  cathodes,   OFF);
               chk("rr_anodes5",   anodes5,    5'h1E);
    goto(32);  chk("rr_frame",     frame_done, 1'b1);
    goto(33);  chk("rr_anodes2",   anodes,     8'hFE);
               chk("rr_discarded", cathodes,   OFF);
               chk("rr_pending",   pending,    1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
